pipeline_register_elastic: RTL and testbench

Parametrised, flow-controlled successor to the fixed MEM/WB pipeline register. It is usable between any two stages of the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries NUM_DATA data words, a destination-register address and CTRL_W control bits.
- Adds a valid/ready handshake, a synchronous flush and a skid slot, so upstream ready is a registered signal and full throughput is kept under back-pressure.
- Exposes occupancy and a saturating stall counter for performance debug.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_slot.sv | 59 +++++
 rtl/pipeline_register_elastic.sv | 144 ++++++++++++++
 tb/tb_pipeline_register_elastic.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: state encoding,
// MEM/WB default widths and control bit positions.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b10
   } state_e;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_NUM_DATA    = 2;
   localparam int DEF_RD_W        = 5;
   localparam int DEF_CTRL_W      = 2;
   localparam int DEF_STALL_CNT_W = 16;

   localparam int REGWRITE = 0;
   localparam int MEMTOREG = 1;

   // Number of entries held in each state.
   function automatic logic [1:0] occ_of(input state_e s);
      logic [1:0] occ;
      case (s)
         EMPTY:   occ = 2'd0;
         FULL:    occ = 2'd1;
         SKID:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload slot (data words, destination register, control bits) with a
// load enable; clears to zero on reset.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_DATA = DEF_NUM_DATA,
   parameter int RD_W     = DEF_RD_W,
   parameter int CTRL_W   = DEF_CTRL_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]            in_rd,
   input  logic [CTRL_W-1:0]          in_ctrl,
   output logic [NUM_DATA*DATA_W-1:0] q_data,
   output logic [RD_W-1:0]            q_rd,
   output logic [CTRL_W-1:0]          q_ctrl
);

   logic [NUM_DATA*DATA_W-1:0] data_q, data_d;
   logic [RD_W-1:0]            rd_q, rd_d;
   logic [CTRL_W-1:0]          ctrl_q, ctrl_d;

   // Next payload: capture the input when loaded, otherwise hold.
   always_comb begin
      data_d = data_q;
      rd_d   = rd_q;
      ctrl_d = ctrl_q;
      if (load) begin
         data_d = in_data;
         rd_d   = in_rd;
         ctrl_d = in_ctrl;
      end else begin
         data_d = data_q;
         rd_d   = rd_q;
         ctrl_d = ctrl_q;
      end
   end

   // Payload registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         rd_q   <= '0;
         ctrl_q <= '0;
      end else begin
         data_q <= data_d;
         rd_q   <= rd_d;
         ctrl_q <= ctrl_d;
      end
   end

   assign q_data = data_q;
   assign q_rd   = rd_q;
   assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipeline_register_elastic.sv
// Two-entry elastic pipeline register (main + skid slot) with registered
// upstream ready, synchronous flush, occupancy and saturating stall counter.
module pipeline_register_elastic
   import pipe_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int NUM_DATA    = DEF_NUM_DATA,
   parameter int RD_W        = DEF_RD_W,
   parameter int CTRL_W      = DEF_CTRL_W,
   parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]            in_rd,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [RD_W-1:0]            out_rd,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [1:0]                 occupancy,
   output logic [STALL_CNT_W-1:0]     stall_count
);

   state_e                     state_q, state_d;
   logic [STALL_CNT_W-1:0]     stall_q, stall_d;
   logic                       accept, drain;
   logic                       load_main, load_skid, main_from_skid;
   logic [NUM_DATA*DATA_W-1:0] main_data, skid_data, main_in_data;
   logic [RD_W-1:0]            main_rd, skid_rd, main_in_rd;
   logic [CTRL_W-1:0]          main_ctrl, skid_ctrl, main_in_ctrl;

   assign out_valid = (state_q != EMPTY);
   assign in_ready  = (state_q != SKID);
   assign occupancy = occ_of(state_q);
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   // Next state and slot load strobes; flush overrides everything.
   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  load_main = 1'b1;
                  state_d   = FULL;
               end else begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (accept && drain) begin
                  load_main = 1'b1;
                  state_d   = FULL;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_d   = SKID;
               end else if (drain) begin
                  state_d = EMPTY;
               end else begin
                  state_d = FULL;
               end
            end
            SKID: begin
               if (drain) begin
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = FULL;
               end else begin
                  state_d = SKID;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Main slot refills from skid when draining out of SKID, else from input.
   always_comb begin
      if (main_from_skid) begin
         main_in_data = skid_data;
         main_in_rd   = skid_rd;
         main_in_ctrl = skid_ctrl;
      end else begin
         main_in_data = in_data;
         main_in_rd   = in_rd;
         main_in_ctrl = in_ctrl;
      end
   end

   // Saturating stall counter; only reset clears it.
   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && !(&stall_q)) begin
         stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_d = stall_q;
      end
   end

   // State and stall counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   pipe_slot #(
      .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W)
   ) u_main (
      .clk(clk), .rst(rst), .load(load_main),
      .in_data(main_in_data), .in_rd(main_in_rd), .in_ctrl(main_in_ctrl),
      .q_data(main_data), .q_rd(main_rd), .q_ctrl(main_ctrl)
   );

   pipe_slot #(
      .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W)
   ) u_skid (
      .clk(clk), .rst(rst), .load(load_skid),
      .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
      .q_data(skid_data), .q_rd(skid_rd), .q_ctrl(skid_ctrl)
   );

   // Bubbles must never look like a register write.
   assign out_data    = main_data;
   assign out_rd      = main_rd & {RD_W{out_valid}};
   assign out_ctrl    = main_ctrl & {CTRL_W{out_valid}};
   assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_register_elastic.sv
// Bench: default MEM/WB instance and a 1x64-bit / 5-ctrl / 4-bit-counter
// instance share stimulus and are compared against a queue-based model.
module tb_pipeline_register_elastic;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_data;
   logic [4:0]  in_rd;
   logic [4:0]  in_ctrl;
   logic        flush;
   logic        out_ready;

   logic        in_ready0, out_valid0, in_ready1, out_valid1;
   logic [63:0] out_data0, out_data1;
   logic [4:0]  out_rd0, out_rd1;
   logic [1:0]  out_ctrl0;
   logic [4:0]  out_ctrl1;
   logic [1:0]  occ0, occ1;
   logic [15:0] stall0;
   logic [3:0]  stall1;

   pipeline_register_elastic dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl[1:0]), .flush(flush),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .out_rd(out_rd0), .out_ctrl(out_ctrl0), .occupancy(occ0), .stall_count(stall0)
   );

   pipeline_register_elastic #(
      .DATA_W(64), .NUM_DATA(1), .RD_W(5), .CTRL_W(5), .STALL_CNT_W(4)
   ) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl), .flush(flush),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .out_rd(out_rd1), .out_ctrl(out_ctrl1), .occupancy(occ1), .stall_count(stall1)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [4:0]  rd;
      logic [4:0]  ctrl;
   } ent_t;

   ent_t mq[$];
   int   stall_m;
   int   n_checks;
   int   n_errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int   n;
      ent_t h;
      n = mq.size();
      check_val("occ0", 64'(occ0), 64'(n));
      check_val("occ1", 64'(occ1), 64'(n));
      check_val("out_valid0", 64'(out_valid0), 64'(n > 0));
      check_val("out_valid1", 64'(out_valid1), 64'(n > 0));
      check_val("in_ready0", 64'(in_ready0), 64'(n < 2));
      check_val("in_ready1", 64'(in_ready1), 64'(n < 2));
      check_val("stall0", 64'(stall0), 64'((stall_m > 65535) ? 65535 : stall_m));
      check_val("stall1", 64'(stall1), 64'((stall_m > 15) ? 15 : stall_m));
      if (n > 0) begin
         h = mq[0];
         check_val("data0", out_data0, h.data);
         check_val("data1", out_data1, h.data);
         check_val("rd0", 64'(out_rd0), 64'(h.rd));
         check_val("rd1", 64'(out_rd1), 64'(h.rd));
         check_val("ctrl0", 64'(out_ctrl0), 64'(h.ctrl[1:0]));
         check_val("ctrl1", 64'(out_ctrl1), 64'(h.ctrl));
      end else begin
         check_val("rd0_bubble", 64'(out_rd0), 64'd0);
         check_val("rd1_bubble", 64'(out_rd1), 64'd0);
         check_val("ctrl0_bubble", 64'(out_ctrl0), 64'd0);
         check_val("ctrl1_bubble", 64'(out_ctrl1), 64'd0);
      end
   endtask

   // Model: FIFO of capacity 2; ready whenever it is not full.
   task automatic model_edge();
      int   n;
      bit   acc, drn;
      ent_t e;
      n   = mq.size();
      acc = in_valid && (n < 2);
      drn = (n > 0) && out_ready;
      if (n > 0 && !out_ready) stall_m++;
      e.data = in_data;
      e.rd   = in_rd;
      e.ctrl = in_ctrl;
      if (flush) begin
         mq.delete();
      end else begin
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
   endtask

   task automatic step(input bit iv, input logic [63:0] d, input logic [4:0] rd,
                       input logic [4:0] c, input bit fl, input bit ordy);
      in_valid  = iv;
      in_data   = d;
      in_rd     = rd;
      in_ctrl   = c;
      flush     = fl;
      out_ready = ordy;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic rand_step();
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      stall_m   = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 64'd0;
      in_rd     = 5'd0;
      in_ctrl   = 5'd0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_all();
      check_val("reset_data0", out_data0, 64'd0);
      check_val("reset_data1", out_data1, 64'd0);

      // Streaming with out_ready held high.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 64'h10 + 64'(i), 5'(i + 1), 5'b00001, 1'b0, 1'b1);
      end
      step(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1);

      // Back-pressure with A, B, C; C waits until ready returns.
      step(1'b1, 64'hA, 5'd10, 5'd1, 1'b0, 1'b0);
      step(1'b1, 64'hB, 5'd11, 5'd2, 1'b0, 1'b0);
      check_val("bp_in_ready", 64'(in_ready0), 64'd0);
      step(1'b1, 64'hC, 5'd12, 5'd3, 1'b0, 1'b0);
      step(1'b1, 64'hC, 5'd12, 5'd3, 1'b0, 1'b1);
      step(1'b1, 64'hC, 5'd12, 5'd3, 1'b0, 1'b1);
      step(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      step(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1);

      // Flush while in SKID, with a simultaneous input.
      step(1'b1, 64'hD, 5'd13, 5'd3, 1'b0, 1'b0);
      step(1'b1, 64'hE, 5'd14, 5'd3, 1'b0, 1'b0);
      step(1'b1, 64'hF, 5'd15, 5'd3, 1'b1, 1'b0);
      check_val("flush_valid", 64'(out_valid0), 64'd0);
      step(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1);

      // Long stall saturates the 4-bit counter.
      step(1'b1, 64'h5A5A, 5'd7, 5'd31, 1'b0, 1'b0);
      repeat (20) step(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      check_val("sat_stall1", 64'(stall1), 64'd15);
      step(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1);

      repeat (300) rand_step();

      // Asynchronous reset mid-operation with entries held.
      step(1'b1, 64'h1234, 5'd3, 5'd3, 1'b0, 1'b0);
      step(1'b1, 64'h5678, 5'd4, 5'd3, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      mq.delete();
      stall_m = 0;
      check_all();
      check_val("arst_data0", out_data0, 64'd0);
      check_val("arst_data1", out_data1, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check_all();

      repeat (200) rand_step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
